writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 125 ++++++++++++
 tb/tb_writeback_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges the single-cycle ALU result stream and a
// buffered long-latency (load/divide) result stream onto one register-file
// write port, and tracks which registers still await a long-latency result.
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ml_valid,
  input  logic [4:0]  ml_rd,
  input  logic [31:0] ml_data,
  output logic        ml_ready,
  input  logic        pend_set,
  input  logic [4:0]  pend_rd,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] pending
);

  // Two-entry result buffer for the long-latency unit.
  logic [4:0]  fifo_rd_mem   [2];
  logic [31:0] fifo_data_mem [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;

  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  logic        reg_write_reg;
  logic [4:0]  write_reg_reg;
  logic [31:0] write_data_reg;

  // Register 0 is never pending, so only bits 31..1 carry state.
  logic [31:1] pending_reg;

  // Readiness depends only on the registered count, never on this cycle's pop,
  // which keeps ml_ready free of any combinational path from alu_valid.
  assign ml_ready  = (count_reg < 2'd2);
  assign push      = ml_valid && ml_ready;
  // The ALU has no backpressure, so it always wins; the buffer drains only
  // in cycles the ALU leaves idle.
  assign pop       = !alu_valid && (count_reg != 2'd0);
  assign head_rd   = fifo_rd_mem[rd_ptr_reg];
  assign head_data = fifo_data_mem[rd_ptr_reg];

  // Count update; a simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Buffer storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= ml_rd;
      fifo_data_mem[wr_ptr_reg] <= ml_data;
    end
  end

  // Buffer pointers and occupancy; reset discards any buffered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Registered write port; address/data hold when nothing is selected, and a
  // selected result targeting r0 is consumed without asserting the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= 5'd0;
      write_data_reg <= 32'd0;
    end else if (alu_valid) begin
      reg_write_reg  <= (alu_rd != 5'd0);
      write_reg_reg  <= alu_rd;
      write_data_reg <= alu_data;
    end else if (pop) begin
      reg_write_reg  <= (head_rd != 5'd0);
      write_reg_reg  <= head_rd;
      write_data_reg <= head_data;
    end else begin
      reg_write_reg  <= 1'b0;
    end
  end

  // Per-register pending bits: set by issue, cleared when the matching
  // long-latency result leaves the buffer; a same-edge set takes priority.
  // ALU writes deliberately do not touch these bits.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending_reg[gi] <= 1'b0;
        end else if (pend_set && (pend_rd == 5'(gi))) begin
          pending_reg[gi] <= 1'b1;
        end else if (pop && (head_rd == 5'(gi))) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign reg_write  = reg_write_reg;
  assign write_reg  = write_reg_reg;
  assign write_data = write_data_reg;
  assign pending    = {pending_reg, 1'b0};

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter. Stimulus pushes the expected write
// sequence into a scoreboard queue; a monitor on the falling edge pops and
// compares every asserted register-file write.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ml_valid;
  logic [4:0]  ml_rd;
  logic [31:0] ml_data;
  logic        ml_ready;
  logic        pend_set;
  logic [4:0]  pend_rd;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  writeback_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ml_valid   (ml_valid),
    .ml_rd      (ml_rd),
    .ml_data    (ml_data),
    .ml_ready   (ml_ready),
    .pend_set   (pend_set),
    .pend_rd    (pend_rd),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every asserted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reg_write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%08h, required no write", write_reg, write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (write_reg !== e.rd || write_data !== e.data) begin
          n_fail++;
          $display("FAIL write: got rd=%0d data=%08h, required rd=%0d data=%08h", write_reg, write_data, e.rd, e.data);
        end else begin
          $display("write ok: rd=%0d data=%08h", write_reg, write_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end else begin
      $display("check ok: %s = %08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_ml(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ml_valid = v;
    ml_rd    = rd;
    ml_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [31:0] pend_snap;
    rst = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ml(1'b0, 5'd0, 32'd0);
    pend_set = 1'b0;
    pend_rd  = 5'd0;

    // Reset state
    #7;
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_ml_ready", {31'd0, ml_ready}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;

    // ALU-only write, then idle
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    chk("alu_reg_write", {31'd0, reg_write}, 32'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("alu_idle_reg_write", {31'd0, reg_write}, 32'd0);

    // ML path with pending tracking
    pend_set = 1'b1; pend_rd = 5'd7;
    step();
    pend_set = 1'b0;
    chk("pend7_set", {31'd0, pending[7]}, 32'd1);
    drive_ml(1'b1, 5'd7, 32'h12345678);
    expect_wr(5'd7, 32'h12345678);
    step();
    drive_ml(1'b0, 5'd0, 32'd0);
    chk("ml_after_push_no_write", {31'd0, reg_write}, 32'd0);
    chk("pend7_held", {31'd0, pending[7]}, 32'd1);
    step();
    chk("ml_write_2_edges", {31'd0, reg_write}, 32'd1);
    chk("pend7_cleared", pending, 32'd0);
    step();

    // Contention and backpressure
    expect_wr(5'd1, 32'hA1A1A1A1);
    expect_wr(5'd2, 32'hA2A2A2A2);
    expect_wr(5'd3, 32'hA3A3A3A3);
    expect_wr(5'd4, 32'hA4A4A4A4);
    expect_wr(5'd10, 32'hC0C0C0C0);
    expect_wr(5'd11, 32'hC1C1C1C1);
    expect_wr(5'd12, 32'hC2C2C2C2);
    drive_alu(1'b1, 5'd1, 32'hA1A1A1A1); drive_ml(1'b1, 5'd10, 32'hC0C0C0C0);
    chk("cont_ready_c1", {31'd0, ml_ready}, 32'd1);
    step();
    drive_alu(1'b1, 5'd2, 32'hA2A2A2A2); drive_ml(1'b1, 5'd11, 32'hC1C1C1C1);
    chk("cont_ready_c2", {31'd0, ml_ready}, 32'd1);
    step();
    drive_alu(1'b1, 5'd3, 32'hA3A3A3A3); drive_ml(1'b1, 5'd12, 32'hC2C2C2C2);
    chk("cont_ready_full_c3", {31'd0, ml_ready}, 32'd0);
    step();
    drive_alu(1'b1, 5'd4, 32'hA4A4A4A4);
    chk("cont_ready_full_c4", {31'd0, ml_ready}, 32'd0);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("cont_ready_full_c5", {31'd0, ml_ready}, 32'd0);
    step();
    chk("cont_ready_c6", {31'd0, ml_ready}, 32'd1);
    step();
    drive_ml(1'b0, 5'd0, 32'd0);
    chk("cont_ready_c7", {31'd0, ml_ready}, 32'd1);
    step();
    step();
    chk("cont_drained_idle", {31'd0, reg_write}, 32'd0);

    // rd=0 result consumed without a write
    pend_snap = pending;
    drive_ml(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    drive_ml(1'b0, 5'd0, 32'd0);
    step();
    chk("rd0_no_write", {31'd0, reg_write}, 32'd0);
    chk("rd0_pending", pending, pend_snap);
    step();

    // Set/clear collision on r3, then ALU write to r3 leaves it pending
    drive_ml(1'b1, 5'd3, 32'h33333333);
    expect_wr(5'd3, 32'h33333333);
    step();
    drive_ml(1'b0, 5'd0, 32'd0);
    pend_set = 1'b1; pend_rd = 5'd3;
    step();
    pend_set = 1'b0;
    chk("collision_pend3", {31'd0, pending[3]}, 32'd1);
    drive_alu(1'b1, 5'd3, 32'hA5A5A5A5);
    expect_wr(5'd3, 32'hA5A5A5A5);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("alu_keeps_pend3", {31'd0, pending[3]}, 32'd1);

    // Reset with a full buffer and pending=0x88
    drive_alu(1'b1, 5'd1, 32'h11111111);
    expect_wr(5'd1, 32'h11111111);
    pend_set = 1'b1; pend_rd = 5'd7;
    drive_ml(1'b1, 5'd20, 32'h20202020);
    step();
    pend_set = 1'b0;
    drive_alu(1'b1, 5'd1, 32'h22222222);
    expect_wr(5'd1, 32'h22222222);
    drive_ml(1'b1, 5'd21, 32'h21212121);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ml(1'b0, 5'd0, 32'd0);
    chk("pre_rst_ready", {31'd0, ml_ready}, 32'd0);
    chk("pre_rst_pending", pending, 32'h00000088);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("mid_rst_write_reg", {27'd0, write_reg}, 32'd0);
    chk("mid_rst_write_data", write_data, 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_ready", {31'd0, ml_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    // First edge after release can already select
    drive_alu(1'b1, 5'd30, 32'h30303030);
    expect_wr(5'd30, 32'h30303030);
    step();
    chk("post_rst_first_write", {31'd0, reg_write}, 32'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", {31'd0, reg_write}, 32'd0);
    end

    // Fresh ML result is the only one that comes out
    drive_ml(1'b1, 5'd22, 32'h22220000);
    expect_wr(5'd22, 32'h22220000);
    step();
    drive_ml(1'b0, 5'd0, 32'd0);
    step();
    chk("post_rst_ml_write", {31'd0, reg_write}, 32'd1);
    repeat (3) step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
